// File: rtl/any1_tlb_walker_pkg.sv
// Shared types for the ANY-1 TLB-miss walker: PTE and TLB entry layouts,
// walker states and fault-cause codes.
package any1_tlb_walker_pkg;

  // Page-table entry as fetched from memory (64-bit bus word).
  typedef struct packed {
    logic [31:0] hi;    // [63:32] not interpreted by the walker
    logic [17:0] ppn;   // [31:14]
    logic [7:0]  rsvd;  // [13:6]
    logic        g;     // [5]
    logic        c;     // [4]
    logic        r;     // [3]
    logic        w;     // [2]
    logic        x;     // [1]
    logic        v;     // [0]
  } pte_t;

  // Entry format written into the TLB.
  typedef struct packed {
    logic [7:0]  vpn;   // [63:56]
    logic [7:0]  asid;  // [55:48]
    logic [15:0] rsvd0; // [47:32]
    logic [17:0] ppn;   // [31:14]
    logic [5:0]  rsvd1; // [13:8]
    logic        d;     // [7]
    logic        a;     // [6]
    logic        g;     // [5]
    logic        c;     // [4]
    logic        r;     // [3]
    logic        w;     // [2]
    logic        x;     // [1]
    logic        v;     // [0]
  } tlb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_RD_PTE,
    ST_CHK,
    ST_WR_TLB,
    ST_DONE,
    ST_FAULT
  } walk_state_e;

  localparam logic [1:0] FLT_NONE   = 2'd0;
  localparam logic [1:0] FLT_INVPTE = 2'd1;
  localparam logic [1:0] FLT_BUSTO  = 2'd2;

  // Fresh entries are marked accessed and clean.
  function automatic tlb_entry_t make_entry(input logic [7:0] vpn,
                                            input logic [7:0] asid,
                                            input pte_t       pte);
    tlb_entry_t e;
    e      = '0;
    e.vpn  = vpn;
    e.asid = asid;
    e.ppn  = pte.ppn;
    e.a    = 1'b1;
    e.d    = 1'b0;
    e.g    = pte.g;
    e.c    = pte.c;
    e.r    = pte.r;
    e.w    = pte.w;
    e.x    = pte.x;
    e.v    = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/any1_tlb_walker.sv
// ANY-1 hardware TLB-miss handler: fetches a single-level PTE, validates it
// and writes the formatted entry into the TLB, or reports a page fault.
module any1_tlb_walker
  import any1_tlb_walker_pkg::*;
#(
  parameter int AWID    = 32,
  parameter int TIMEOUT = 255,
  parameter bit RANDWAY = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            miss_i,
  input  logic [AWID-1:0] miss_adr_i,
  input  logic [7:0]      asid_i,
  input  logic [AWID-1:0] ptbr_i,
  input  logic            flush_i,
  input  logic            tlb_rdy_i,
  output logic            req_o,
  output logic [AWID-1:0] adr_o,
  input  logic            ack_i,
  input  logic [63:0]     dat_i,
  output logic            wrtlb_o,
  output logic [15:0]     tlbadr_o,
  output logic [63:0]     tlbdat_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [1:0]      cause_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  walk_state_e     state, state_nxt;
  logic [AWID-1:14] vpage;
  logic [7:0]      asid_q;
  logic [AWID-1:0] ptbr_q;
  pte_t            pte_q;
  tlb_entry_t      entry_q;
  logic            flush_pend;
  logic [7:0]      tmo_cnt;
  logic [7:0]      tmo_nxt;
  logic [1:0]      way_cnt;
  logic [1:0]      cause_q;
  logic            accept;
  logic            flush_seen;
  logic            tmo_hit;
  logic            unused_bits;

  assign unused_bits = ^{miss_adr_i[13:0], pte_q.hi, pte_q.rsvd};

  // Shared decode of the walk-start, flush and timeout conditions.
  always_comb begin
    accept     = (state == ST_IDLE) && miss_i && !flush_i;
    flush_seen = flush_pend || flush_i;
    tmo_nxt    = tmo_cnt + 8'd1;
    tmo_hit    = (state == ST_RD_PTE) && !ack_i && (tmo_nxt == TMO_LIMIT);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a flush during the bus read is honoured only once the
  // read has finished (ack or timeout), so the bus cycle is never abandoned.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (accept) state_nxt = tlb_rdy_i ? ST_RD_PTE : ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (flush_i)        state_nxt = ST_IDLE;
        else if (tlb_rdy_i) state_nxt = ST_RD_PTE;
      end
      ST_RD_PTE: begin
        if (ack_i)        state_nxt = ST_CHK;
        else if (tmo_hit) state_nxt = flush_seen ? ST_IDLE : ST_FAULT;
      end
      ST_CHK: begin
        if (flush_seen)    state_nxt = ST_IDLE;
        else if (!pte_q.v) state_nxt = ST_FAULT;
        else               state_nxt = ST_WR_TLB;
      end
      ST_WR_TLB: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_FAULT:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Walk context, PTE capture, counters and fault cause.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vpage      <= '0;
      asid_q     <= '0;
      ptbr_q     <= '0;
      pte_q      <= '0;
      entry_q    <= '0;
      flush_pend <= 1'b0;
      tmo_cnt    <= '0;
      way_cnt    <= '0;
      cause_q    <= FLT_NONE;
    end else begin
      if (accept) begin
        vpage      <= miss_adr_i[AWID-1:14];
        asid_q     <= asid_i;
        ptbr_q     <= ptbr_i;
        flush_pend <= 1'b0;
        tmo_cnt    <= '0;
        cause_q    <= FLT_NONE;
      end
      if (state == ST_RD_PTE) begin
        flush_pend <= flush_seen;
        if (ack_i) pte_q <= dat_i;
        else       tmo_cnt <= tmo_nxt;
        if (tmo_hit && !flush_seen) cause_q <= FLT_BUSTO;
      end
      if (state == ST_CHK && !flush_seen) begin
        if (!pte_q.v) cause_q <= FLT_INVPTE;
        else          entry_q <= make_entry(vpage[31:24], asid_q, pte_q);
      end
      if (state == ST_WR_TLB && !RANDWAY) way_cnt <= way_cnt + 2'd1;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_o    = 1'b0;
    adr_o    = '0;
    wrtlb_o  = 1'b0;
    tlbadr_o = '0;
    tlbdat_o = '0;
    busy_o   = (state != ST_IDLE);
    done_o   = (state == ST_DONE);
    fault_o  = (state == ST_FAULT);
    cause_o  = cause_q;
    if (state == ST_RD_PTE) begin
      req_o = 1'b1;
      adr_o = ptbr_q + AWID'({vpage, 3'b000});
    end
    if (state == ST_WR_TLB) begin
      wrtlb_o        = 1'b1;
      tlbdat_o       = entry_q;
      tlbadr_o[9:0]  = vpage[23:14];
      tlbadr_o[15]   = RANDWAY;
      tlbadr_o[11:10] = RANDWAY ? 2'd0 : way_cnt;
    end
  end

endmodule

// File: doc/any1_tlb_walker.md
Name: any1_tlb_walker

Overview:
- Hardware TLB-miss handler for the ANY-1 core, sitting between the core's TLB (miss/write port) and the data-side bus master.
- On a miss it fetches a single-level page-table entry (PTE) from memory and validates it.
- A valid PTE is formatted into a TLBEntry and written into the TLB with a replacement-way selection.
- An invalid PTE or a bus timeout is reported to the core as a page fault.

Parameters:
- AWID, 32, virtual/physical address width.
- TIMEOUT, 255, bus cycles to wait for ack_i before declaring a bus fault (8-bit counter).
- RANDWAY, 1, 1 = request random-way write (tlbadr_o[15]=1); 0 = round-robin way in tlbadr_o[11:10].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous and active-high.
- miss_i  in  1  TLB miss, level-sensitive, sampled in IDLE.
- miss_adr_i  in  AWID  faulting virtual address.
- asid_i  in  8  current address-space ID.
- ptbr_i  in  AWID  page-table base, 8-byte aligned.
- flush_i  in  1  abandon the walk (context switch or exception).
- tlb_rdy_i  in  1  TLB reset-fill complete.
- req_o  out  1  bus read request.
- adr_o  out  AWID  bus read address.
- ack_i  in  1  bus read acknowledge.
- dat_i  in  64  bus read data.
- wrtlb_o  out  1  TLB write strobe.
- tlbadr_o  out  16  TLB write address.
- tlbdat_o  out  64  TLB entry data.
- busy_o  out  1  walk in progress.
- done_o  out  1  one-cycle pulse: entry written.
- fault_o  out  1  one-cycle pulse: walk failed.
- cause_o  out  2  0 none, 1 invalid PTE, 2 bus timeout; held until next walk.

Behaviour:
- Reset values: state IDLE, all outputs 0, way counter 0, timeout counter 0.
- IDLE:
  - miss_i & !flush_i → latch miss_adr_i, asid_i, ptbr_i; clear cause_o.
  - If tlb_rdy_i, go to RD_PTE; otherwise go to WAIT_RDY.
  - busy_o rises the cycle after the miss is accepted.
- WAIT_RDY:
  - tlb_rdy_i → RD_PTE.
  - flush_i → IDLE, with no outputs.
- RD_PTE:
  - req_o=1 and adr_o = ptbr + {adr[AWID-1:14],3'b000}. Address arithmetic is modulo 2^AWID; carries wrap silently.
  - ack_i → capture dat_i and go to CHK.
  - The timeout counter increments each cycle without ack. On reaching TIMEOUT: cause=2, go to FAULT, drop req_o.
  - flush_i is ignored here but remembered. The walk continues until ack or timeout, then the result is discarded and the FSM returns to IDLE without done_o or fault_o.
- CHK (1 cycle):
  - PTE.V=0 → cause=1, go to FAULT.
  - Otherwise build the entry: vpn=adr[31:24], ASID=latched asid, ppn=PTE[31:14], G/C/R/W/X from PTE, A=1, D=0. Go to WR_TLB.
  - A pending flush → IDLE.
- WR_TLB (1 cycle):
  - wrtlb_o=1 and tlbadr_o[9:0]=adr[23:14].
  - RANDWAY=1: tlbadr_o[15]=1 and [11:10]=0.
  - RANDWAY=0: tlbadr_o[15]=0, [11:10]=way counter, then the way counter increments and wraps 3→0.
  - Go to DONE.
- DONE: done_o=1 for one cycle, then IDLE with busy_o=0.
- FAULT: fault_o=1 for one cycle, cause_o valid, then IDLE.
- Back-to-back walks: a miss held across DONE/FAULT is not accepted until the cycle after the return to IDLE (minimum one idle cycle).
- Latency on a hit-in-memory with tlb_rdy_i=1 and ack at wait n: miss accepted at cycle 0, done_o at cycle 3+n.
- Reset mid-walk: immediate return to IDLE with all outputs 0, including mid-bus-cycle; the bus slave tolerates the dropped request.
- wrtlb_o and req_o are never asserted in the same cycle.

Decomposition:
- any1_pkg additions:
  - Pte typedef (V[0], X[1], W[2], R[3], C[4], G[5], ppn[31:14]).
  - Walker state enum.
  - Fault-cause constants (FLT_NONE, FLT_INVPTE, FLT_BUSTO).
- Reuse the existing TLBEntry typedef for tlbdat_o.
- No sub-module. The timeout counter and way counter are inline.

Test Plan:
- Valid PTE: ptbr=0x1000, miss_adr=0x0123_4000, dat_i=0x0000_8039 (V,R,C,G set; ppn from [31:14]) on 2nd ack cycle → adr_o=0x1000+0x48D*8=0x3468; wrtlb_o with tlbadr_o=0x808D; done_o at cycle 5.
- Invalid PTE: dat_i bit0=0 → fault_o pulse, cause_o=1, no wrtlb_o.
- Timeout: TIMEOUT=4, ack_i never asserted → req_o drops after 4 cycles, fault_o, cause_o=2.
- Flush in RD_PTE: flush_i pulsed, ack after 3 cycles → no wrtlb_o, no done_o or fault_o, busy_o=0 next cycle.
- RANDWAY=0: four successive valid misses → tlbadr_o[11:10] = 0,1,2,3, then 0 on the fifth.
- tlb_rdy_i=0 at miss, raised 10 cycles later → req_o first asserted the cycle after tlb_rdy_i. Async reset mid-RD_PTE → req_o and busy_o drop immediately.
